// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle mult/div unit owning HI/LO, Busy held while an operation runs.
// Optional MD_CANCEL_EN adds a cancel input that aborts in-flight ops and suppresses requests.
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MDStart,
  input  logic [2:0]  MDOp,
  input  logic        HLOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
`ifdef MD_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        Busy,
  output logic [31:0] HLOut
);
  localparam logic [1:0] IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2;
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  logic [1:0]  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic        sgn_q, sgn_d;
  logic        kill, idle, start_mul, start_div, mthi, mtlo;
  logic signed [32:0] ma, mb;
  logic signed [63:0] prod;
  logic [31:0] abs_a, abs_b, dvs, q_mag, r_mag, quo, rem;
`ifdef MD_CANCEL_EN
  assign kill = cancel;
`else
  assign kill = 1'b0;
`endif
  assign idle      = state_q == IDLE;
  assign start_mul = idle & MDStart & (MDOp == 3'd1 | MDOp == 3'd2) & ~kill;
  assign start_div = idle & MDStart & (MDOp == 3'd3 | MDOp == 3'd4) & ~kill;
  assign mthi      = idle & (MDOp == 3'd5) & ~kill;
  assign mtlo      = idle & (MDOp == 3'd6) & ~kill;
  assign Busy      = ~idle;
  assign HLOut     = HLOp ? hi_q : lo_q;
  // One extra operand bit lets a single signed multiplier serve both mult and multu.
  assign ma    = {sgn_q & a_q[31], a_q};
  assign mb    = {sgn_q & b_q[31], b_q};
  assign prod  = ma * mb;
  assign abs_a = (sgn_q & a_q[31]) ? -a_q : a_q;
  assign abs_b = (sgn_q & b_q[31]) ? -b_q : b_q;
  assign dvs   = (b_q == 32'd0) ? 32'd1 : abs_b;
  assign q_mag = abs_a / dvs;
  assign r_mag = abs_a % dvs;
  assign quo   = (sgn_q & (a_q[31] ^ b_q[31])) ? -q_mag : q_mag;
  assign rem   = (sgn_q & a_q[31]) ? -r_mag : r_mag;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    hi_d    = mthi ? A : hi_q;
    lo_d    = mtlo ? A : lo_q;
    if (start_mul | start_div) begin
      state_d = start_mul ? MUL : DIV;
      cnt_d   = start_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      a_d     = A;
      b_d     = B;
      sgn_d   = (MDOp == 3'd1) | (MDOp == 3'd3);
    end
    if (~idle & kill) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (~idle) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d = IDLE;
        if (state_q == MUL) {hi_d, lo_d} = prod;
        else if (b_q != 32'd0) {hi_d, lo_d} = {rem, quo};
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: directed vector table plus hand sequences for div-by-zero, reset abort and cancel.
module tb_md_sequencer;
  logic        clk = 1'b0;
  logic        reset, MDStart, HLOp, Busy;
  logic [2:0]  MDOp;
  logic [31:0] A, B, HLOut;
  int          n_cmp = 0, n_fail = 0, n;
`ifdef MD_CANCEL_EN
  logic        cancel = 1'b0;
`endif
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    int          cyc;
  } vec_t;
  vec_t v[10];

  md_sequencer dut (
    .clk(clk), .reset(reset), .MDStart(MDStart), .MDOp(MDOp), .HLOp(HLOp),
    .A(A), .B(B),
`ifdef MD_CANCEL_EN
    .cancel(cancel),
`endif
    .Busy(Busy), .HLOut(HLOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic read_hl(input string name, input logic [31:0] hi, input logic [31:0] lo);
    HLOp = 1'b1;
    #1 check({name, " HI"}, HLOut, hi);
    HLOp = 1'b0;
    #1 check({name, " LO"}, HLOut, lo);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int cnt);
    MDOp = op; A = a; B = b; MDStart = 1'b1;
    tick;
    MDStart = 1'b0; MDOp = 3'd0; A = ~a; B = 32'h5a5a_5a5a;
    cnt = 0;
    while (Busy && cnt < 64) begin
      cnt++;
      tick;
    end
  endtask

  task automatic move(input logic [2:0] op, input logic [31:0] val, input logic st);
    MDOp = op; A = val; MDStart = st;
    tick;
    MDOp = 3'd0; MDStart = 1'b0;
  endtask

  initial begin
    v[0] = '{3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    v[1] = '{3'd2, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5};
    v[2] = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    v[3] = '{3'd4, 32'd7,        32'd2,        32'h00000001, 32'h00000003, 10};
    v[4] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    v[5] = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    v[6] = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 10};
    v[7] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    v[8] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    v[9] = '{3'd1, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 5};
    reset = 1'b0; MDStart = 1'b0; MDOp = 3'd0; HLOp = 1'b0; A = '0; B = '0;
    #3 check("reset Busy", {31'd0, Busy}, 32'd0);
    read_hl("reset", 32'd0, 32'd0);
    #6 reset = 1'b1;
    tick;
    MDOp = 3'd5; A = 32'h12345678; HLOp = 1'b1;
    #1 check("mthi old value", HLOut, 32'd0);
    tick;
    check("mthi Busy", {31'd0, Busy}, 32'd0);
    MDOp = 3'd6; A = 32'h9ABCDEF0;
    tick;
    check("mtlo Busy", {31'd0, Busy}, 32'd0);
    MDOp = 3'd0;
    read_hl("mthi/mtlo", 32'h12345678, 32'h9ABCDEF0);
    for (int i = 0; i < 10; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, n);
      check($sformatf("vec%0d busy cycles", i), n, v[i].cyc);
      read_hl($sformatf("vec%0d", i), v[i].hi, v[i].lo);
    end
    move(3'd5, 32'h11, 1'b1);
    check("mthi+start Busy", {31'd0, Busy}, 32'd0);
    move(3'd6, 32'h22, 1'b1);
    read_hl("move with start", 32'h11, 32'h22);
    MDOp = 3'd3; A = 32'd100; B = 32'd0; MDStart = 1'b1;
    tick;
    n = 0;
    while (Busy && n < 64) begin
      if (n == 2) begin
        MDStart = 1'b1; MDOp = 3'd1; A = 32'd9; B = 32'd9;
      end else if (n == 4) begin
        MDStart = 1'b0; MDOp = 3'd6; A = 32'hDEAD;
      end else begin
        MDStart = 1'b0; MDOp = 3'd0;
      end
      n++;
      tick;
    end
    MDStart = 1'b0; MDOp = 3'd0;
    check("div0 busy cycles", n, 32'd10);
    read_hl("div0", 32'h11, 32'h22);
    tick;
    check("div0 no restart", {31'd0, Busy}, 32'd0);
    MDStart = 1'b1; MDOp = 3'd0;
    tick;
    check("start op0 ignored", {31'd0, Busy}, 32'd0);
    MDOp = 3'd7;
    tick;
    check("start op7 ignored", {31'd0, Busy}, 32'd0);
    MDStart = 1'b0; MDOp = 3'd0;
    read_hl("bad ops", 32'h11, 32'h22);
    MDOp = 3'd1; A = 32'd3; B = 32'd4; MDStart = 1'b1;
    tick;
    MDStart = 1'b0; MDOp = 3'd0;
    tick;
    #2 reset = 1'b0;
    #1 check("async reset Busy", {31'd0, Busy}, 32'd0);
    read_hl("async reset", 32'd0, 32'd0);
    @(negedge clk) reset = 1'b1;
    tick;
    check("post reset Busy", {31'd0, Busy}, 32'd0);
`ifdef MD_CANCEL_EN
    move(3'd5, 32'd5, 1'b0);
    move(3'd6, 32'd6, 1'b0);
    MDOp = 3'd1; A = 32'd3; B = 32'd4; MDStart = 1'b1;
    tick;
    MDStart = 1'b0; MDOp = 3'd0;
    tick;
    tick;
    cancel = 1'b1;
    tick;
    cancel = 1'b0;
    check("cancel Busy", {31'd0, Busy}, 32'd0);
    read_hl("cancel", 32'd5, 32'd6);
    cancel = 1'b1; MDStart = 1'b1; MDOp = 3'd2;
    tick;
    check("cancel start Busy", {31'd0, Busy}, 32'd0);
    MDStart = 1'b0; MDOp = 3'd5; A = 32'd9;
    tick;
    cancel = 1'b0; MDOp = 3'd0;
    read_hl("cancel move", 32'd5, 32'd6);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Multi-cycle multiply/divide unit and HI/LO register owner for the P6 pipeline; sits in the E stage.
- Accepts MDOp/MDStart from the decoder and runs the selected operation over a fixed cycle count.
- Holds Busy so the hazard unit stalls later multiply/divide and mfhi/mflo instructions.
- Returns HI or LO to the E-stage forwarding mux, selected by HLOp.

Parameters:
- MULT_CYCLES, 5, Busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, Busy cycles for div/divu (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- MDStart  in  1  one-cycle start pulse for mult/multu/div/divu.
- MDOp  in  3  0 OTH, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO.
- HLOp  in  1  1 read HI, 0 read LO.
- A  in  32  rs operand, forwarded.
- B  in  32  rt operand, forwarded.
- Busy  out  1  operation in flight.
- HLOut  out  32  HLOp ? HI : LO, combinational from the architectural registers.

Behaviour:
- Reset (reset==0, asynchronous): HI=0, LO=0, state=IDLE, counter=0, Busy=0, latched operands cleared.
- States and transitions:
  - IDLE -> MUL: MDStart & MDOp∈{1,2}.
  - IDLE -> DIV: MDStart & MDOp∈{3,4}.
  - MUL/DIV -> IDLE: counter reaches 1.
  - No other transitions.
- Start edge: A, B and the signedness bit are latched into internal regs. Counter loads MULT_CYCLES or DIV_CYCLES. Busy rises on the following cycle.
- Busy=1 exactly N cycles after the start edge (N = MULT_CYCLES or DIV_CYCLES). Counter decrements once per cycle.
- Completion edge (counter==1): HI/LO commit and Busy falls on that same edge. Results are readable through HLOut in the first cycle with Busy=0.
- Results:
  - mult: {HI,LO} = $signed(A)*$signed(B), full 64 bits.
  - multu: the same product, unsigned.
  - div: LO = signed quotient, HI = signed remainder, truncated toward zero, remainder takes the sign of the dividend.
  - divu: the same operation, unsigned.
- Arithmetic is computed from the latched operands only, so input changes during Busy have no effect.
- Divide by zero (B==0 for div/divu): counter still runs the full DIV_CYCLES. HI/LO are left unchanged.
- Signed overflow (0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0.
- MTHI/MTLO when state==IDLE: HI (or LO) <= A on the edge, with no Busy. A same-edge read via HLOut returns the old value.
- MTHI/MTLO while Busy: ignored, HI/LO unchanged. The hazard unit is required to stall it, and the block must not corrupt state if it arrives anyway.
- MDStart while Busy: ignored, the in-flight operation continues unchanged.
- MDStart with MDOp outside 1..4: ignored.
- MDOp 5/6 with MDStart=1: treated as MTHI/MTLO, and MDStart is ignored.
- Reset mid-operation: abort immediately, Busy=0, HI/LO=0.

Optional Feature:
- Macro: MD_CANCEL_EN.
- Defined:
  - Adds input `cancel` (1 bit), used for exception flush in P7.
  - cancel=1 with Busy=1: the next edge returns the unit to IDLE, Busy=0, and HI/LO keep their pre-operation values.
  - cancel=1 in the same cycle as MDStart or MTHI/MTLO: that request is suppressed.
  - cancel in IDLE with no request: no effect.
- Undefined: the port is absent, and every operation that starts runs to completion.

Test Plan:
- Reset released, MDStart MULT, A=0xFFFFFFFE (-2), B=3 -> Busy=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=0xFFFFFFF9 (-7), B=2 -> Busy=1 for 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7, B=2 -> LO=3, HI=1.
- MTHI A=0x12345678, then MTLO A=0x9ABCDEF0 in IDLE -> HLOut=0x12345678 when HLOp=1 and 0x9ABCDEF0 when HLOp=0, Busy never asserts.
- DIV B=0 after HI=0x11, LO=0x22 -> Busy for 10 cycles, HI=0x11, LO=0x22; a second MDStart MULT at cycle 3 of Busy -> ignored, and Busy ends on cycle 10.
- Reset asserted at cycle 2 of a MULT -> Busy=0 and HI=LO=0 immediately, without waiting for a clock edge.
- With MD_CANCEL_EN: HI=5, LO=6, MULT 3×4, cancel at cycle 3 -> Busy=0 next cycle, HI=5, LO=6 unchanged.
